// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: turns memory-stage load/store requests into
// handshaked bus transfers, stalling the pipeline until each transfer retires.
module dmem_access_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read_m,
    input  logic        mem_write_m,
    input  logic [31:0] addr_m,
    input  logic [31:0] wdata_m,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    output logic        misalign_o,
    output logic        timeout_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rvalid_q, rvalid_d;
    logic        misalign_q, misalign_d;
    logic        timeout_q, timeout_d;

    logic access, aligned, pending;

    assign access  = mem_read_m | mem_write_m;
    assign aligned = (addr_m[1:0] == 2'b00);
    assign pending = access & aligned;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        rvalid_d   = 1'b0;
        misalign_d = 1'b0;
        timeout_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pending) begin
                    addr_d  = addr_m;
                    wdata_d = wdata_m;
                    we_d    = mem_write_m;
                    cnt_d   = '0;
                    req_d   = 1'b1;
                    state_d = ST_REQ;
                end else if (access) begin
                    misalign_d = 1'b1;
                end
            end
            ST_REQ: begin
                // Ack takes priority over timeout in the final wait cycle.
                if (bus_ack) begin
                    if (!we_q) begin
                        rdata_d  = bus_rdata;
                        rvalid_d = 1'b1;
                    end
                    req_d   = 1'b0;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d   = '0;
                    timeout_d = 1'b1;
                    req_d     = 1'b0;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: begin
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            misalign_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            misalign_q <= misalign_d;
            timeout_q  <= timeout_d;
        end
    end

    assign stall_o       = ((state_q == ST_IDLE) && pending) || (state_q == ST_REQ);
    assign bus_req       = req_q;
    assign bus_we        = we_q;
    assign bus_addr      = addr_q;
    assign bus_wdata     = wdata_q;
    assign rdata_o       = rdata_q;
    assign rdata_valid_o = rvalid_q;
    assign misalign_o    = misalign_q;
    assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: a transaction-level schedule of expected outputs
// is compared with the DUT every cycle, plus literal checks on directed cases.
module tb_dmem_access_ctrl;

    localparam int unsigned TO = 16;

    logic        clk;
    logic        rst_n;
    logic        mem_read_m, mem_write_m;
    logic [31:0] addr_m, wdata_m;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        stall_o;
    logic [31:0] rdata_o;
    logic        rdata_valid_o, misalign_o, timeout_o;

    dmem_access_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read_m(mem_read_m), .mem_write_m(mem_write_m),
        .addr_m(addr_m), .wdata_m(wdata_m),
        .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .stall_o(stall_o), .rdata_o(rdata_o),
        .rdata_valid_o(rdata_valid_o), .misalign_o(misalign_o),
        .timeout_o(timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected outputs for the current cycle, and one-cycle pulses owed next cycle.
    logic        e_stall, e_req, e_we, e_valid, e_mis, e_to;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic        c_valid, c_mis, c_to;

    // Running counts of observed output activity, used by the literal checks.
    int m_stall = 0, m_req = 0, m_valid = 0, m_mis = 0, m_to = 0, m_we = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Drive one cycle's inputs, compare all outputs mid-cycle, advance past the edge.
    task automatic cycle(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic ack, input logic [31:0] rdat,
                         input logic xs, input logic xr);
        mem_read_m  = rd;
        mem_write_m = wr;
        addr_m      = a;
        wdata_m     = wd;
        bus_ack     = ack;
        bus_rdata   = rdat;
        e_stall = xs;
        e_req   = xr;
        e_valid = c_valid;
        e_mis   = c_mis;
        e_to    = c_to;
        c_valid = 1'b0;
        c_mis   = 1'b0;
        c_to    = 1'b0;
        @(negedge clk);
        chk("stall_o", stall_o, e_stall);
        chk("bus_req", bus_req, e_req);
        chk("rdata_valid_o", rdata_valid_o, e_valid);
        chk("misalign_o", misalign_o, e_mis);
        chk("timeout_o", timeout_o, e_to);
        chk("rdata_o", rdata_o, e_rdata);
        if (e_req) begin
            chk("bus_we", bus_we, e_we);
            chk("bus_addr", bus_addr, e_addr);
            chk("bus_wdata", bus_wdata, e_wdata);
        end
        if (stall_o) m_stall++;
        if (bus_req) m_req++;
        if (rdata_valid_o) m_valid++;
        if (misalign_o) m_mis++;
        if (timeout_o) m_to++;
        if (bus_req && bus_we) m_we++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, $urandom, $urandom, rbit(), $urandom, 1'b0, 1'b0);
    endtask

    // One memory-stage access; delay = REQ cycles before ack, >= TO means never acked.
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] wd, input int delay, input logic [31:0] rv);
        int n;
        if (!(rd | wr)) begin
            cycle(rd, wr, a, wd, rbit(), $urandom, 1'b0, 1'b0);
            return;
        end
        if (a[1:0] != 2'b00) begin
            cycle(rd, wr, a, wd, rbit(), $urandom, 1'b0, 1'b0);
            c_mis = 1'b1;
            return;
        end
        e_we    = wr;
        e_addr  = a;
        e_wdata = wd;
        cycle(rd, wr, a, wd, rbit(), $urandom, 1'b1, 1'b0);
        n = (delay < int'(TO)) ? delay + 1 : int'(TO);
        for (int k = 0; k < n; k++)
            cycle(rbit(), rbit(), $urandom, $urandom, (k == delay),
                  (k == delay) ? rv : $urandom, 1'b1, 1'b1);
        if (delay < int'(TO)) begin
            if (!wr) begin
                e_rdata = rv;
                c_valid = 1'b1;
            end
        end else begin
            e_rdata = 32'h0;
            c_to    = 1'b1;
        end
        cycle(rbit(), rbit(), $urandom, $urandom, rbit(), $urandom, 1'b0, 1'b0);
    endtask

    initial begin
        int s_stall, s_req, s_valid, s_mis, s_to, s_we;
        logic [31:0] wd;
        int kind, op, dsel, dly;
        logic [31:0] a;

        mem_read_m = 1'b0; mem_write_m = 1'b0; addr_m = '0; wdata_m = '0;
        bus_ack = 1'b0; bus_rdata = '0;
        e_we = 1'b0; e_addr = '0; e_wdata = '0; e_rdata = '0;
        c_valid = 1'b0; c_mis = 1'b0; c_to = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("reset bus_req", bus_req, 1'b0);
        chk("reset bus_addr", bus_addr, 32'h0);
        chk("reset rdata_o", rdata_o, 32'h0);
        chk("reset stall idle", stall_o, 1'b0);
        mem_read_m = 1'b1; addr_m = 32'h40;
        #1 chk("reset stall aligned", stall_o, 1'b1);
        mem_read_m = 1'b0; addr_m = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Load, immediate ack
        s_stall = m_stall; s_valid = m_valid;
        do_access(1'b1, 1'b0, 32'h100, $urandom, 0, 32'hDEADBEEF);
        idle();
        chk("ld stall cycles", m_stall - s_stall, 2);
        chk("ld valid pulses", m_valid - s_valid, 1);
        chk("ld rdata", rdata_o, 32'hDEADBEEF);

        // Store, ack after 3 wait cycles
        s_stall = m_stall; s_req = m_req; s_valid = m_valid; s_we = m_we;
        do_access(1'b0, 1'b1, 32'h204, 32'h12345678, 3, $urandom);
        idle();
        chk("st stall cycles", m_stall - s_stall, 5);
        chk("st req cycles", m_req - s_req, 4);
        chk("st we cycles", m_we - s_we, 4);
        chk("st valid pulses", m_valid - s_valid, 0);

        // Load that never gets acked
        s_req = m_req; s_to = m_to; s_valid = m_valid;
        do_access(1'b1, 1'b0, 32'h300, $urandom, 1000, $urandom);
        idle();
        chk("to req cycles", m_req - s_req, 16);
        chk("to pulses", m_to - s_to, 1);
        chk("to valid pulses", m_valid - s_valid, 0);
        chk("to rdata", rdata_o, 32'h0);

        // Misaligned load
        s_mis = m_mis; s_stall = m_stall; s_req = m_req;
        do_access(1'b1, 1'b0, 32'h102, $urandom, 0, $urandom);
        idle();
        chk("mis pulses", m_mis - s_mis, 1);
        chk("mis stall cycles", m_stall - s_stall, 0);
        chk("mis req cycles", m_req - s_req, 0);

        // Reset asserted mid-REQ
        wd = $urandom;
        e_we = 1'b0; e_addr = 32'h40; e_wdata = wd;
        cycle(1'b1, 1'b0, 32'h40, wd, 1'b0, $urandom, 1'b1, 1'b0);
        repeat (3) cycle(rbit(), rbit(), $urandom, $urandom, 1'b0, $urandom, 1'b1, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst bus_req", bus_req, 1'b0);
        chk("arst bus_we", bus_we, 1'b0);
        chk("arst bus_addr", bus_addr, 32'h0);
        chk("arst bus_wdata", bus_wdata, 32'h0);
        chk("arst rdata_o", rdata_o, 32'h0);
        chk("arst valid", rdata_valid_o, 1'b0);
        chk("arst misalign", misalign_o, 1'b0);
        chk("arst timeout", timeout_o, 1'b0);
        mem_read_m = 1'b1; mem_write_m = 1'b0; addr_m = 32'h80;
        #1 chk("arst stall aligned", stall_o, 1'b1);
        mem_read_m = 1'b0; mem_write_m = 1'b0;
        #1 chk("arst stall idle", stall_o, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        e_rdata = 32'h0; c_valid = 1'b0; c_mis = 1'b0; c_to = 1'b0;
        s_valid = m_valid;
        do_access(1'b1, 1'b0, 32'h0, $urandom, 1, 32'hCAFEF00D);
        idle();
        chk("post-rst valid", m_valid - s_valid, 1);
        chk("post-rst rdata", rdata_o, 32'hCAFEF00D);

        // Read+write together, then a back-to-back load
        s_we = m_we; s_valid = m_valid; s_stall = m_stall;
        do_access(1'b1, 1'b1, 32'h8, 32'hA5A5_0001, 0, $urandom);
        do_access(1'b1, 1'b0, 32'hC, $urandom, 0, 32'h5A5A_1234);
        idle();
        chk("rw we cycles", m_we - s_we, 1);
        chk("rw valid pulses", m_valid - s_valid, 1);
        chk("b2b stall cycles", m_stall - s_stall, 4);
        chk("b2b rdata", rdata_o, 32'h5A5A_1234);

        // Randomized traffic
        repeat (250) begin
            kind = $urandom_range(0, 9);
            op   = $urandom_range(0, 2);
            dsel = $urandom_range(0, 9);
            if (dsel == 0)      dly = int'(TO) + 5;
            else if (dsel == 1) dly = int'(TO) - 1;
            else                dly = $urandom_range(0, 4);
            a = $urandom;
            if (kind == 1) begin
                if (a[1:0] == 2'b00) a[1:0] = 2'($urandom_range(1, 3));
            end else begin
                a[1:0] = 2'b00;
            end
            if (kind == 0)
                do_access(1'b0, 1'b0, a, $urandom, dly, $urandom);
            else
                do_access(op != 1, op != 0, a, $urandom, dly, $urandom);
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl.md
DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL set the maximum REQ-state cycles to wait for bus_ack (legal range 2..255).
REQ-002 clk  input  1  SHALL be the rising-edge clock for all state.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 mem_read_m  input  1  SHALL indicate that the memory stage holds a load (ResultSrcM == 2'b01).
REQ-005 mem_write_m  input  1  SHALL indicate that the memory stage holds a store (MemWriteM).
REQ-006 addr_m  input  32  SHALL carry the access address (ALUResultM).
REQ-007 wdata_m  input  32  SHALL carry the store data (WriteDataM).
REQ-008 bus_req  output  1  SHALL request a data-bus transfer.
REQ-009 bus_we  output  1  SHALL mark the transfer as a write.
REQ-010 bus_addr  output  32  SHALL carry the registered transfer address.
REQ-011 bus_wdata  output  32  SHALL carry the registered write data.
REQ-012 bus_ack  input  1  SHALL mark transfer completion; bus_rdata is valid in the same cycle.
REQ-013 bus_rdata  input  32  SHALL carry the read data.
REQ-014 stall_o  output  1  SHALL freeze the fetch, decode, execute and memory pipeline registers while high.
REQ-015 rdata_o  output  32  SHALL carry the load result for the memory/writeback register.
REQ-016 rdata_valid_o  output  1  SHALL pulse for one cycle when rdata_o holds new load data.
REQ-017 misalign_o  output  1  SHALL pulse for one cycle on a misaligned access.
REQ-018 timeout_o  output  1  SHALL pulse for one cycle when an access times out.

Function
REQ-019 The FSM SHALL have exactly three states, IDLE, REQ and DONE, encoded in 2 bits; any unused encoding SHALL go to IDLE on the next clock.
REQ-020 An access is pending when (mem_read_m | mem_write_m) is high and addr_m[1:0] == 2'b00.
REQ-021 In IDLE with an access pending, the block SHALL:
- register addr_m, wdata_m and we = mem_write_m into the bus outputs;
- clear the timeout counter;
- move to REQ on the next clock.
REQ-022 stall_o SHALL be combinational: high when (state == IDLE and access pending) or state == REQ, and low in DONE.
REQ-023 In REQ, bus_req SHALL be 1, and bus_we, bus_addr and bus_wdata SHALL be held stable until bus_ack or timeout.
REQ-024 In REQ with bus_ack = 1, the block SHALL:
- capture bus_rdata into rdata_o when the access is a read;
- move to DONE on the next clock.
REQ-025 In REQ with bus_ack = 0, the counter SHALL increment each cycle.
REQ-026 When the counter equals TIMEOUT-1 with bus_ack = 0, the block SHALL:
- drop bus_req on the next clock;
- set rdata_o to 32'h0;
- move to DONE;
- pulse timeout_o for one cycle in DONE.
REQ-027 In DONE, rdata_valid_o SHALL be 1 for exactly one cycle for a read that completed with ack; it SHALL stay 0 for a write or a timeout. The next state SHALL be IDLE.
REQ-028 Minimum latency SHALL be 3 cycles per access (IDLE, REQ with immediate ack, DONE). A back-to-back access presented in the cycle after DONE SHALL start in IDLE with no lost cycle.
REQ-029 If mem_read_m and mem_write_m are both 1, the access SHALL be treated as a write and rdata_valid_o SHALL stay 0.
REQ-030 A misaligned access (addr_m[1:0] != 0) in IDLE SHALL:
- issue no bus request;
- pulse misalign_o for one cycle;
- keep stall_o low;
- leave the FSM in IDLE.
REQ-031 rdata_o SHALL hold its last value except where it is updated under REQ-024 or REQ-026.
REQ-032 bus_ack received outside REQ SHALL be ignored.
REQ-033 Inputs mem_read_m, mem_write_m, addr_m and wdata_m SHALL NOT be sampled outside IDLE; they are frozen by stall_o.

Reset
REQ-034 On rst_n low, the block SHALL immediately, and at any point including mid-transfer:
- set the state to IDLE;
- clear the counter;
- drive bus_req, bus_we, rdata_valid_o, misalign_o and timeout_o to 0;
- drive bus_addr, bus_wdata and rdata_o to 32'h0.
REQ-035 stall_o SHALL follow REQ-022 from the reset state, so it is high only if an aligned access is present during reset.

Verification
REQ-036 Load addr_m = 32'h100, with bus_ack in the first REQ cycle and bus_rdata = 32'hDEADBEEF -> stall_o high for 2 cycles, then rdata_o = 32'hDEADBEEF with rdata_valid_o = 1 for 1 cycle.
REQ-037 Store addr_m = 32'h204, wdata_m = 32'h12345678, with ack delayed 3 cycles -> bus_we = 1, address and data stable through all 4 REQ cycles, stall_o high for 5 cycles, rdata_valid_o stays 0.
REQ-038 Load with bus_ack never asserted and TIMEOUT = 16 -> bus_req high for exactly 16 cycles, then timeout_o pulses once, rdata_o = 0, FSM returns to IDLE.
REQ-039 Load with addr_m = 32'h102 -> no bus_req, misalign_o pulses once, stall_o stays 0.
REQ-040 rst_n pulsed low during REQ -> bus_req drops asynchronously and all outputs take their reset values. A following load at 32'h0 then completes normally.
REQ-041 Read and write both asserted on addr_m = 32'h8, followed immediately by a load -> bus_we = 1 for the first transfer, and the second access starts in the cycle after DONE.
